// File: rtl/tri_port_cam_regfile.sv
// tri_port_cam_regfile: register file with one write, one read and one CAM search port.
// Ports:
//   clk_in, reset_in (async, active-low)
//   write_en_in / write_entry_addr_decoded_in / write_entry_in : multi-hot broadcast write
//   read_en_in / read_entry_addr_decoded_in -> read_entry_out   : registered OR of selected entries
//   cam_en_in / cam_entry_in -> cam_result_decoded_out          : registered per-entry match vector
module tri_port_cam_regfile #(
    parameter int SINGLE_ENTRY_WIDTH_IN_BITS = 8,
    parameter int NUM_ENTRY = 4
) (
    input  logic                                  clk_in,
    input  logic                                  reset_in,
    input  logic                                  read_en_in,
    input  logic                                  write_en_in,
    input  logic                                  cam_en_in,
    input  logic [NUM_ENTRY-1:0]                  read_entry_addr_decoded_in,
    input  logic [NUM_ENTRY-1:0]                  write_entry_addr_decoded_in,
    input  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] cam_entry_in,
    input  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] write_entry_in,
    output logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] read_entry_out,
    output logic [NUM_ENTRY-1:0]                  cam_result_decoded_out
);
    localparam int W = SINGLE_ENTRY_WIDTH_IN_BITS;

    logic [W-1:0]         entry_q [NUM_ENTRY];
    logic [W-1:0]         entry_d [NUM_ENTRY];
    logic [W-1:0]         read_q, read_d;
    logic [NUM_ENTRY-1:0] cam_q, cam_d;

    // Read and CAM both look at entry_q, so they observe pre-write contents.
    always_comb begin
        read_d = read_en_in ? '0 : read_q;
        cam_d  = '0;
        for (int i = 0; i < NUM_ENTRY; i++) begin
            entry_d[i] = (write_en_in && write_entry_addr_decoded_in[i]) ? write_entry_in : entry_q[i];
            read_d     = (read_en_in && read_entry_addr_decoded_in[i]) ? (read_d | entry_q[i]) : read_d;
            cam_d[i]   = cam_en_in && (entry_q[i] == cam_entry_in);
        end
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            for (int i = 0; i < NUM_ENTRY; i++) entry_q[i] <= '0;
            read_q <= '0;
            cam_q  <= '0;
        end else begin
            for (int i = 0; i < NUM_ENTRY; i++) entry_q[i] <= entry_d[i];
            read_q <= read_d;
            cam_q  <= cam_d;
        end
    end

    assign read_entry_out         = read_q;
    assign cam_result_decoded_out = cam_q;
endmodule

// File: tb/tb_tri_port_cam_regfile.sv
// tb_tri_port_cam_regfile: scoreboard bench with a behavioural reference model and randomized traffic.
module tb_tri_port_cam_regfile;
    localparam int W = 8;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset_in = 1'b1;
    logic         read_en_in = 1'b0;
    logic         write_en_in = 1'b0;
    logic         cam_en_in = 1'b0;
    logic [N-1:0] read_entry_addr_decoded_in = '0;
    logic [N-1:0] write_entry_addr_decoded_in = '0;
    logic [W-1:0] cam_entry_in = '0;
    logic [W-1:0] write_entry_in = '0;
    logic [W-1:0] read_entry_out;
    logic [N-1:0] cam_result_decoded_out;

    tri_port_cam_regfile #(.SINGLE_ENTRY_WIDTH_IN_BITS(W), .NUM_ENTRY(N)) dut (
        .clk_in(clk),
        .reset_in(reset_in),
        .read_en_in(read_en_in),
        .write_en_in(write_en_in),
        .cam_en_in(cam_en_in),
        .read_entry_addr_decoded_in(read_entry_addr_decoded_in),
        .write_entry_addr_decoded_in(write_entry_addr_decoded_in),
        .cam_entry_in(cam_entry_in),
        .write_entry_in(write_entry_in),
        .read_entry_out(read_entry_out),
        .cam_result_decoded_out(cam_result_decoded_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] rd;
        logic [N-1:0] cam;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: storage as a plain array, outputs recomputed from the rules on every
    // clock edge or reset assertion, with the expected outputs queued for the monitor.
    initial begin
        logic [W-1:0] mem [N];
        logic [W-1:0] rd_m;
        logic [N-1:0] cam_m;
        for (int i = 0; i < N; i++) mem[i] = '0;
        rd_m  = '0;
        cam_m = '0;
        forever begin
            @(posedge clk or negedge reset_in);
            if (!reset_in) begin
                for (int i = 0; i < N; i++) mem[i] = '0;
                rd_m  = '0;
                cam_m = '0;
            end else begin
                if (read_en_in) begin
                    rd_m = '0;
                    for (int i = 0; i < N; i++) if (read_entry_addr_decoded_in[i]) rd_m = rd_m | mem[i];
                end
                for (int i = 0; i < N; i++) cam_m[i] = cam_en_in && (mem[i] == cam_entry_in);
                if (write_en_in)
                    for (int i = 0; i < N; i++) if (write_entry_addr_decoded_in[i]) mem[i] = write_entry_in;
            end
            q.push_back('{rd_m, cam_m});
        end
    end

    // Monitor: outputs are sampled shortly after every event that can change them.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or negedge reset_in);
            #2;
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty t=%0t", $time);
            end else begin
                e = q.pop_front();
                if (read_entry_out !== e.rd) begin
                    errors++;
                    $display("FAIL read_entry_out t=%0t got=%h exp=%h", $time, read_entry_out, e.rd);
                end
                checks++;
                if (cam_result_decoded_out !== e.cam) begin
                    errors++;
                    $display("FAIL cam_result t=%0t got=%b exp=%b", $time, cam_result_decoded_out, e.cam);
                end
            end
        end
    end

    task automatic cyc(input logic re, input logic we, input logic ce, input logic [N-1:0] ra,
                       input logic [N-1:0] wa, input logic [W-1:0] key, input logic [W-1:0] wd);
        @(negedge clk);
        read_en_in                  = re;
        write_en_in                 = we;
        cam_en_in                   = ce;
        read_entry_addr_decoded_in  = ra;
        write_entry_addr_decoded_in = wa;
        cam_entry_in                = key;
        write_entry_in              = wd;
        @(posedge clk);
    endtask

    // Reset asserted between clock edges to exercise its asynchronous effect.
    task automatic pulse_reset();
        @(negedge clk);
        #2 reset_in = 1'b0;
        @(negedge clk);
        reset_in = 1'b1;
    endtask

    function automatic logic [W-1:0] pick_data();
        logic [W-1:0] v [5];
        v = '{8'h00, 8'hF0, 8'h0F, 8'h55, 8'hAA};
        return ($urandom_range(0, 3) == 0) ? W'($urandom) : v[$urandom_range(0, 4)];
    endfunction

    initial begin
        #1 reset_in = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_in = 1'b1;
        // basic write then read
        cyc(0, 1, 0, 4'b0000, 4'b0001, 8'h00, 8'hF0);
        cyc(1, 0, 0, 4'b0001, 4'b0000, 8'h00, 8'h00);
        // write enable gating
        cyc(1, 1, 0, 4'b0001, 4'b0001, 8'h00, 8'hF0);
        cyc(1, 0, 0, 4'b0001, 4'b0001, 8'h00, 8'h0F);
        cyc(1, 0, 0, 4'b0001, 4'b0001, 8'h00, 8'h0F);
        // CAM after reset
        pulse_reset();
        cyc(0, 0, 1, 4'b0000, 4'b0000, 8'hF0, 8'h00);
        cyc(0, 0, 1, 4'b0000, 4'b0000, 8'h00, 8'h00);
        // broadcast write plus CAM
        cyc(0, 1, 0, 4'b0000, 4'b1111, 8'h00, 8'hF0);
        cyc(0, 0, 1, 4'b0000, 4'b0000, 8'hF0, 8'h00);
        cyc(0, 1, 0, 4'b0000, 4'b1010, 8'h00, 8'h0F);
        cyc(0, 0, 1, 4'b0000, 4'b0000, 8'hF0, 8'h00);
        // read-during-write, CAM-during-write, then reset mid-operation
        cyc(0, 1, 0, 4'b0000, 4'b0100, 8'h00, 8'h55);
        cyc(1, 1, 1, 4'b0100, 4'b0100, 8'h55, 8'hAA);
        cyc(1, 0, 1, 4'b0100, 4'b0000, 8'hAA, 8'h00);
        cyc(1, 0, 1, 4'b1111, 4'b0000, 8'hAA, 8'h00);
        pulse_reset();
        for (int i = 0; i < N; i++) cyc(1, 0, 0, 4'(1 << i), 4'b0000, 8'h00, 8'h00);
        // enable deassertion
        cyc(1, 1, 1, 4'b0000, 4'b0010, 8'h00, 8'h3C);
        cyc(1, 0, 1, 4'b0010, 4'b0000, 8'h3C, 8'h00);
        cyc(0, 0, 0, 4'b0001, 4'b0000, 8'h3C, 8'h00);
        cyc(0, 0, 0, 4'b1111, 4'b0000, 8'h3C, 8'h00);
        // randomized traffic with occasional mid-run resets
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 63) == 0) pulse_reset();
            else cyc(1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0), N'($urandom), N'($urandom),
                     pick_data(), pick_data());
        end
        @(negedge clk);
        #3;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
